// File: rtl/operand_buffer_if.sv
// Write/read bus for operand_buffer: write port, fill status, flush controls and NUM_RD read ports.
// master = producer/sequencer side, slave = the buffer itself.
interface operand_buffer_if #(
  parameter int DATA_W = 8,
  parameter int A_DIM  = 4,
  parameter int B_DIM  = 3,
  parameter int NUM_RD = 3
);
  localparam int AW = $clog2(A_DIM * A_DIM);
  localparam int CW = $clog2(A_DIM * A_DIM + B_DIM * B_DIM + 1);

  logic                       clear;
  logic                       wr_valid;
  logic                       wr_ready;
  logic                       wr_sel;
  logic [AW-1:0]              wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       wr_err;
  logic                       full;
  logic [CW-1:0]              fill_count;
  logic                       release_req;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*(AW+1)-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_valid;

  modport master (
    output clear, wr_valid, wr_sel, wr_addr, wr_data, release_req, rd_en, rd_addr,
    input  wr_ready, wr_err, full, fill_count, rd_data, rd_valid
  );

  modport slave (
    input  clear, wr_valid, wr_sel, wr_addr, wr_data, release_req, rd_en, rd_addr,
    output wr_ready, wr_err, full, fill_count, rd_data, rd_valid
  );
endinterface

// File: rtl/operand_buffer.sv
// Operand store for the systolic convolution datapath: one A_DIM^2 input matrix, one B_DIM^2 filter,
// fill tracking with a FULL lock, and NUM_RD registered read ports with zero-padded out-of-range reads.
module operand_buffer #(
  parameter int DATA_W = 8,
  parameter int A_DIM  = 4,
  parameter int B_DIM  = 3,
  parameter int NUM_RD = 3
) (
  input logic             clk,
  input logic             rst,
  operand_buffer_if.slave bus
);
  localparam int A_N   = A_DIM * A_DIM;
  localparam int B_N   = B_DIM * B_DIM;
  localparam int TOTAL = A_N + B_N;
  localparam int AW    = $clog2(A_N);
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [AW:0]   A_LIM   = (AW+1)'(A_N);
  localparam logic [AW:0]   B_LIM   = (AW+1)'(B_N);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   a_mem [A_N];
  logic [DATA_W-1:0]   b_mem [B_N];
  logic [A_N-1:0]      a_valid;
  logic [B_N-1:0]      b_valid;
  logic                err_q;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]   rd_valid_q;
  logic [DATA_W-1:0]   rd_word [NUM_RD];

  logic wr_ready, wr_in_range, wr_accept, already, new_entry, err_d, flush;

  // Write qualification, fill accounting and state transitions.
  always_comb begin
    wr_ready    = (state_q != FULL);
    wr_in_range = bus.wr_sel ? ({1'b0, bus.wr_addr} < B_LIM)
                             : ({1'b0, bus.wr_addr} < A_LIM);
    wr_accept   = bus.wr_valid && wr_ready && wr_in_range && !bus.clear;
    already     = bus.wr_sel ? b_valid[bus.wr_addr] : a_valid[bus.wr_addr];
    new_entry   = wr_accept && !already;
    err_d       = bus.wr_valid && wr_ready && !wr_in_range && !bus.clear;
    flush       = bus.clear || (bus.release_req && state_q == FULL);

    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = EMPTY;
      count_d = '0;
    end else if (wr_accept) begin
      count_d = count_q + CW'(new_entry);
      state_d = (count_d == TOTAL_C) ? FULL : FILLING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage survives flushes; only the valid bitmaps are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < A_N; i++) a_mem[i] <= '0;
      for (int i = 0; i < B_N; i++) b_mem[i] <= '0;
      a_valid <= '0;
      b_valid <= '0;
    end else if (flush) begin
      a_valid <= '0;
      b_valid <= '0;
    end else if (wr_accept) begin
      if (bus.wr_sel) begin
        b_mem[bus.wr_addr]   <= bus.wr_data;
        b_valid[bus.wr_addr] <= 1'b1;
      end else begin
        a_mem[bus.wr_addr]   <= bus.wr_data;
        a_valid[bus.wr_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_word[k] = '0;
      if (bus.rd_addr[k*(AW+1)+AW]) begin
        if ({1'b0, bus.rd_addr[k*(AW+1) +: AW]} < B_LIM)
          rd_word[k] = b_mem[bus.rd_addr[k*(AW+1) +: AW]];
      end else if ({1'b0, bus.rd_addr[k*(AW+1) +: AW]} < A_LIM) begin
        rd_word[k] = a_mem[bus.rd_addr[k*(AW+1) +: AW]];
      end
    end
  end

  // Registered read ports; data holds when a port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      for (int k = 0; k < NUM_RD; k++)
        if (bus.rd_en[k]) rd_data_q[k*DATA_W +: DATA_W] <= rd_word[k];
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.full       = (state_q == FULL);
  assign bus.fill_count = count_q;
  assign bus.wr_err     = err_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
endmodule
